serial_divider: RTL
===================

Name: serial_divider

Overview:
- Sequential restoring divider, the inverse of the team's shift-add serial multiplier.
- Takes a 2N-bit dividend (e.g. a multiplier product) and an N-bit divisor, and produces an N-bit quotient and an N-bit remainder.
- Processes one quotient bit per clock.
- Sits beside the serial multiplier in the arithmetic datapath and uses the same clk/rst naming.

Parameters:
- N, 4, operand width; dividend is 2N bits, divisor, quotient and remainder are N bits.

Ports:
- clk  input  1  system clock; all logic is on the rising edge
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- start  input  1  request a division; accepted only in IDLE
- P  input  2N  dividend; sampled on the accepting edge
- b  input  N  divisor; sampled on the accepting edge
- q  output  N  quotient
- r  output  N  remainder
- busy  output  1  high while a division is in progress (CALC)
- done  output  1  one-cycle completion pulse
- ovf  output  1  quotient does not fit in N bits
- dz  output  1  divide by zero

Behaviour:
- Reset (rst==0 at an edge): state=IDLE; q, r, busy, done, ovf, dz all 0; internal registers cleared. Reset has priority over everything, including mid-CALC, where the operation is abandoned and no done pulse is produced.
- States: IDLE, CALC, FIN.
- IDLE, start==1: capture b. Check in this order:
  - b==0: go to FIN; dz=1 (see Optional Feature).
  - P[2N-1:N] >= b: go to FIN; ovf=1.
  - Otherwise: R = {1'b0, P[2N-1:N]} (N+1 bits); L = P[N-1:0]; count = 0; go to CALC.
- IDLE, start==0: hold state; q and r hold their previous results.
- CALC, each cycle:
  - t = {R[N-1:0], L[N-1]} (N+1 bits).
  - If t >= b: R = t - b and qbit = 1; else R = t and qbit = 0.
  - L = {L[N-2:0], qbit}; count++.
  - After the N-th step (count == N-1 at the edge): go to FIN.
- FIN:
  - done=1 for exactly one cycle. Valid case: q = L, r = R[N-1:0], ovf = 0, dz = 0.
  - Error case: q=0, r=0, with the corresponding flag set.
  - Next state is IDLE.
- Flags ovf/dz: cleared when the next start is accepted; otherwise held.
- busy = (state==CALC).
- start is ignored in CALC and FIN; there is no queueing.
- Latency, with the accepting edge as cycle 0:
  - Valid divide: done high in cycle N+1.
  - Error: done high in cycle 1.
- Next accept: start may be accepted in the cycle after done, i.e. back-to-back with a one-cycle IDLE gap.
- Invariants on valid results: P == q*b + r and r < b.
- Arithmetic: all comparisons are unsigned; the subtraction is N+1 bits wide and never underflows because it is guarded by the compare.

Optional Feature:
- Macro: SERIAL_DIV_ZERO_CHECK_EN.
- Defined: b==0 is detected explicitly, giving dz=1, ovf=0, q=0, r=0, with done in cycle 1.
- Undefined: no explicit check. The dz port is tied to 0, and b==0 falls into the overflow check (P_hi >= 0 is always true), giving ovf=1 with done in cycle 1. No other behaviour differs.

Test Plan:
- N=4, P=100, b=7, start pulse -> busy for 4 cycles; done in cycle 5; q=14, r=2, ovf=0, dz=0.
- P=224, b=15 -> q=14, r=14. P=0, b=5 -> q=0, r=0. P=15, b=1 -> q=15, r=0. All with done in cycle 5.
- Overflow: P=255, b=15 -> done in cycle 1, ovf=1, q=0, r=0. Then P=100, b=7 on the next start -> ovf cleared, q=14.
- Divide by zero: P=50, b=0 -> with macro, dz=1, ovf=0; without macro, ovf=1, dz=0. Done in cycle 1 in both builds.
- Protocol:
  - Start (with different operands) held high during CALC -> ignored; original result delivered.
  - Reset (rst=0) in CALC cycle 2 -> next cycle all outputs 0, state IDLE, no done pulse.
  - A subsequent start completes normally.
- Exhaustive: every P in 0..255 and b in 1..15 with P[7:4] < b -> q*b + r == P and r < b. All other pairs -> ovf=1.

Source files
------------

// File: rtl/serial_divider.sv
// Restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder, one quotient bit per clock.
// Latency: done in cycle N+1, or in cycle 1 on overflow or div-by-zero. Start is ignored unless idle. Optional macro: SERIAL_DIV_ZERO_CHECK_EN.
module serial_divider #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] P,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   q,
  output logic [N-1:0]   r,
  output logic           busy,
  output logic           done,
  output logic           ovf,
  output logic           dz
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_rem,   w_rem_nxt;
  logic [N-1:0]  r_lo,    w_lo_nxt;
  logic [N-1:0]  r_div,   w_div_nxt;
  logic [N-1:0]  r_q,     w_q_nxt;
  logic [N-1:0]  r_r,     w_r_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic          r_ovf,   w_ovf_nxt;
  logic          r_dz,    w_dz_nxt;

  logic [N:0]    w_t;
  logic [N-1:0]  w_diff;
  logic          w_qbit;
  logic          w_div_zero;

`ifdef SERIAL_DIV_ZERO_CHECK_EN
  assign w_div_zero = (b == '0);
`else
  // Without the check, b==0 falls through to the overflow compare (P_hi >= 0).
  assign w_div_zero = 1'b0;
`endif

  // The partial remainder is always < b after a step, so N bits hold it.
  assign w_t    = {r_rem, r_lo[N-1]};
  assign w_qbit = (w_t >= {1'b0, r_div});
  assign w_diff = w_t[N-1:0] - r_div;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_lo    <= '0;
      r_div   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_lo    <= w_lo_nxt;
      r_div   <= w_div_nxt;
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
      r_dz    <= w_dz_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_lo_nxt    = r_lo;
    w_div_nxt   = r_div;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_dz_nxt    = r_dz;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_div_nxt = b;
          w_ovf_nxt = 1'b0;
          w_dz_nxt  = 1'b0;
          if (w_div_zero) begin
            w_dz_nxt    = 1'b1;
            w_q_nxt     = '0;
            w_r_nxt     = '0;
            w_state_nxt = S_FIN;
          end else if (P[2*N-1:N] >= b) begin
            w_ovf_nxt   = 1'b1;
            w_q_nxt     = '0;
            w_r_nxt     = '0;
            w_state_nxt = S_FIN;
          end else begin
            w_rem_nxt   = P[2*N-1:N];
            w_lo_nxt    = P[N-1:0];
            w_cnt_nxt   = '0;
            w_state_nxt = S_CALC;
          end
        end
      end
      S_CALC: begin
        w_rem_nxt = w_qbit ? w_diff : w_t[N-1:0];
        w_lo_nxt  = {r_lo[N-2:0], w_qbit};
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CW'(N-1)) begin
          w_q_nxt     = w_lo_nxt;
          w_r_nxt     = w_rem_nxt;
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign q    = r_q;
  assign r    = r_r;
  assign ovf  = r_ovf;
  assign dz   = r_dz;
  assign busy = (r_state == S_CALC);
  assign done = (r_state == S_FIN);

endmodule
